// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths, defaults and result record for the FFT peak detector.
package fft_pkg;

    localparam int MAG_W     = 32;
    localparam int BIN_W     = 16;
    localparam int FRAME_LEN = 1024;

    localparam logic [BIN_W-1:0] NO_PEAK_BIN = 16'hFFFF;

    typedef struct packed {
        logic [MAG_W-1:0] mag;
        logic [BIN_W-1:0] bin;
        logic [15:0]      frame_idx;
        logic             len_err;
    } peak_result_t;

endpackage

// File: rtl/fft_peak_detector_if.sv
// rtl/fft_peak_detector_if.sv - magnitude input stream and peak result stream of the detector.
interface fft_peak_detector_if #(
    parameter int MAG_W = 32,
    parameter int BIN_W = 16
);

    logic [MAG_W-1:0] s_axis_mag_tdata;
    logic [BIN_W-1:0] s_axis_mag_tuser;
    logic             s_axis_mag_tlast;
    logic             s_axis_mag_tvalid;

    logic [MAG_W-1:0] m_axis_peak_tdata;
    logic [BIN_W-1:0] m_axis_peak_tuser;
    logic             m_axis_peak_tvalid;
    logic             m_axis_peak_tready;

    // Detector side: consumes magnitudes, produces peak results.
    modport slave (
        input  s_axis_mag_tdata,
        input  s_axis_mag_tuser,
        input  s_axis_mag_tlast,
        input  s_axis_mag_tvalid,
        output m_axis_peak_tdata,
        output m_axis_peak_tuser,
        output m_axis_peak_tvalid,
        input  m_axis_peak_tready
    );

    modport master (
        output s_axis_mag_tdata,
        output s_axis_mag_tuser,
        output s_axis_mag_tlast,
        output s_axis_mag_tvalid,
        input  m_axis_peak_tdata,
        input  m_axis_peak_tuser,
        input  m_axis_peak_tvalid,
        output m_axis_peak_tready
    );

endinterface

// File: rtl/fft_peak_detector_hold.sv
// rtl/fft_peak_detector_hold.sv - axis_hold_reg: one-deep result register with drop and sticky overflow.
module axis_hold_reg
    import fft_pkg::*;
(
    input  logic         aclk,
    input  logic         areset,
    input  logic         load,
    input  peak_result_t din,
    input  logic         tready,
    output logic         tvalid,
    output peak_result_t dout,
    output logic         overflow
);

    // A new result may replace the held one only if the held one leaves this cycle.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            tvalid   <= 1'b0;
            dout     <= '0;
            overflow <= 1'b0;
        end else if (load) begin
            if (!tvalid || tready) begin
                dout   <= din;
                tvalid <= 1'b1;
            end else begin
                overflow <= 1'b1;
            end
        end else if (tvalid && tready) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/fft_peak_detector.sv
// rtl/fft_peak_detector.sv - per-frame windowed peak search over an FFT magnitude stream.
// Optional PEAK_THRESHOLD_EN adds peak_threshold; frames whose peak falls below it emit nothing.
module fft_peak_detector #(
    parameter int FRAME_LEN = 1024,
    parameter int MIN_BIN   = 1,
    parameter int MAX_BIN   = 511,
    parameter int MAG_W     = 32,
    parameter int BIN_W     = 16
) (
    input  logic                   aclk,
    input  logic                   areset,
    fft_peak_detector_if.slave     bus,
`ifdef PEAK_THRESHOLD_EN
    input  logic [MAG_W-1:0]       peak_threshold,
`endif
    output logic [15:0]            frame_idx,
    output logic                   len_err,
    output logic                   overflow
);

    import fft_pkg::*;

    localparam logic [15:0]      LEN_TARGET = 16'(FRAME_LEN);
    localparam logic [BIN_W-1:0] WIN_LO     = BIN_W'(MIN_BIN);
    localparam logic [BIN_W-1:0] WIN_HI     = BIN_W'(MAX_BIN);

    logic [15:0]      beat_cnt;
    logic [15:0]      frame_cnt;
    logic [MAG_W-1:0] best_mag;
    logic [BIN_W-1:0] best_bin;

    logic [15:0]      beat_next;
    logic             in_win;
    logic             take;
    logic             frame_end;
    logic             load;
    logic [MAG_W-1:0] cur_mag;
    logic [BIN_W-1:0] cur_bin;
    peak_result_t     result;
    peak_result_t     held;
    logic             peak_tvalid;

    // cur_* is the running best including the current beat, so the tlast beat joins the final compare.
    always_comb begin
        beat_next = (beat_cnt == 16'hFFFF) ? beat_cnt : beat_cnt + 16'd1;
        in_win    = (bus.s_axis_mag_tuser >= WIN_LO) && (bus.s_axis_mag_tuser <= WIN_HI);
        take      = bus.s_axis_mag_tvalid && in_win && (bus.s_axis_mag_tdata > best_mag);
        cur_mag   = take ? bus.s_axis_mag_tdata : best_mag;
        cur_bin   = take ? bus.s_axis_mag_tuser : best_bin;
        frame_end = bus.s_axis_mag_tvalid && bus.s_axis_mag_tlast;

        result.mag       = cur_mag;
        result.bin       = cur_bin;
        result.frame_idx = frame_cnt;
        result.len_err   = (beat_next != LEN_TARGET);

`ifdef PEAK_THRESHOLD_EN
        load = frame_end && (cur_mag >= peak_threshold);
`else
        load = frame_end;
`endif
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            beat_cnt  <= '0;
            frame_cnt <= '0;
            best_mag  <= '0;
            best_bin  <= NO_PEAK_BIN;
        end else if (frame_end) begin
            beat_cnt  <= '0;
            frame_cnt <= frame_cnt + 16'd1;
            best_mag  <= '0;
            best_bin  <= NO_PEAK_BIN;
        end else if (bus.s_axis_mag_tvalid) begin
            beat_cnt <= beat_next;
            best_mag <= cur_mag;
            best_bin <= cur_bin;
        end
    end

    axis_hold_reg u_hold (
        .aclk     (aclk),
        .areset   (areset),
        .load     (load),
        .din      (result),
        .tready   (bus.m_axis_peak_tready),
        .tvalid   (peak_tvalid),
        .dout     (held),
        .overflow (overflow)
    );

    assign bus.m_axis_peak_tvalid = peak_tvalid;
    assign bus.m_axis_peak_tdata  = held.mag;
    assign bus.m_axis_peak_tuser  = held.bin;
    assign frame_idx              = held.frame_idx;
    assign len_err                = held.len_err;

endmodule
